// File: rtl/alu_pkg.sv
// alu_pkg: opcode enum, flag bit positions and opcode helpers shared by the ALU pipeline
package alu_pkg;
  typedef enum logic [1:0] {ADD, SUB, NAND, XOR} alu_op_e;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;
  function automatic logic is_arith(input alu_op_e op);
    return op == ADD || op == SUB;
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing wrapped result and signed-overflow error
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_e          i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_error
);
  logic [WIDTH-1:0] w_sum, w_diff;
  logic             w_sa, w_sb;
  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_sa   = i_a[WIDTH-1];
  assign w_sb   = i_b[WIDTH-1];
  always_comb begin
    o_result = i_op == ADD ? w_sum : i_op == SUB ? w_diff : i_op == NAND ? ~(i_a & i_b) : i_a ^ i_b;
    o_error  = i_op == ADD ? (w_sa == w_sb) && (w_sum[WIDTH-1] != w_sa) :
               i_op == SUB ? (w_sa != w_sb) && (w_diff[WIDTH-1] != w_sa) : 1'b0;
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline with condition flags and saturating error counter
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_error,
  output logic [2:0]       flags,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_count
);
  logic             r_s1_v, r_s2_v, r_err, r_arith;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  alu_op_e          r_op;
  logic [2:0]       r_flags;
  logic [CNT_W-1:0] r_cnt;
  logic             w_out_xfer, w_s1_adv, w_in_xfer, w_err;
  logic [WIDTH-1:0] w_res;
  assign w_out_xfer = r_s2_v & out_ready;
  assign w_s1_adv   = r_s1_v & (~r_s2_v | out_ready);
  assign in_ready   = rst_n & (~r_s1_v | w_s1_adv);
  assign w_in_xfer  = in_valid & in_ready;
  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_res),
    .o_error  (w_err)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= ADD;
    end else begin
      if (w_in_xfer) begin
        r_a  <= in_a;
        r_b  <= in_b;
        r_op <= alu_op_e'(in_op);
      end
      r_s1_v <= w_in_xfer | (r_s1_v & ~w_s1_adv);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_v  <= 1'b0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_arith <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_res   <= w_res;
        r_err   <= w_err;
        r_arith <= is_arith(r_op);
      end
      r_s2_v <= w_s1_adv | (r_s2_v & ~out_ready);
    end
  end
  // V only follows arithmetic results; logic ops leave it untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_out_xfer) begin
      r_flags[FLAG_Z] <= r_res == '0;
      r_flags[FLAG_N] <= r_res[WIDTH-1];
      if (r_arith) r_flags[FLAG_V] <= r_err;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) r_cnt <= '0;
    else if (w_out_xfer && r_err && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
  end
  assign out_valid  = r_s2_v;
  assign out_result = r_res;
  assign out_error  = r_err;
  assign flags      = r_flags;
  assign err_count  = r_cnt;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: vector table, directed corner sequences and random traffic against a queue-based model
module tb_alu_pipe;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, out_ready, clr_cnt;
  logic [3:0] in_a, in_b;
  logic [1:0] in_op;
  logic       in_ready, out_valid, out_error;
  logic [3:0] out_result;
  logic [2:0] flags;
  logic [7:0] err_count;
  logic       in_ready2, out_valid2, out_error2;
  logic [3:0] out_result2;
  logic [2:0] flags2;
  logic [1:0] err_count2;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  alu_pipe #(.WIDTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_error(out_error), .flags(flags), .clr_cnt(clr_cnt), .err_count(err_count)
  );
  alu_pipe #(.WIDTH(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
    .out_error(out_error2), .flags(flags2), .clr_cnt(clr_cnt), .err_count(err_count2)
  );
  typedef struct {logic [3:0] res; logic err; logic arith;} exp_t;
  typedef struct {logic [3:0] a, b; logic [1:0] op; logic [3:0] res; logic err; logic [2:0] fl; int cnt;} vec_t;
  exp_t q[$];
  logic [2:0] m_flags = '0;
  int m_cnt = 0, m_cnt2 = 0;
  logic mon_on = 1'b0, hold = 1'b0, p_err;
  logic [3:0] p_res;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic exp_t ref_model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    exp_t e;
    int s;
    s = 0;
    e.arith = op < 2;
    e.err = 1'b0;
    if (op == 0) s = $signed(a) + $signed(b);
    if (op == 1) s = $signed(a) - $signed(b);
    e.res = op == 2 ? ~(a & b) : op == 3 ? a ^ b : s[3:0];
    if (e.arith) e.err = s > 7 || s < -8;
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      chk("mon_flags", flags, m_flags);
      chk("mon_cnt", err_count, m_cnt);
      chk("mon_cnt2", err_count2, m_cnt2);
      chk("mon_dut2_valid", out_valid2, out_valid);
      chk("mon_dut2_res", out_result2, out_result);
      if (out_valid && q.size() == 0) chk("mon_spurious_out", out_valid, 0);
      if (hold && rst_n) begin
        chk("mon_hold_valid", out_valid, 1);
        chk("mon_hold_res", out_result, p_res);
        chk("mon_hold_err", out_error, p_err);
      end
      if (!rst_n) begin
        q.delete();
        m_flags = '0;
        m_cnt = 0;
        m_cnt2 = 0;
        hold = 1'b0;
      end else begin
        if (out_valid && out_ready && q.size() > 0) begin
          e = q.pop_front();
          chk("mon_res", out_result, e.res);
          chk("mon_err", out_error, e.err);
          m_flags[2] = e.res == 0;
          m_flags[0] = e.res[3];
          if (e.arith) m_flags[1] = e.err;
          if (!clr_cnt && e.err) begin
            m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
            m_cnt2 = m_cnt2 < 3 ? m_cnt2 + 1 : 3;
          end
        end
        if (clr_cnt) begin
          m_cnt = 0;
          m_cnt2 = 0;
        end
        if (in_valid && in_ready) q.push_back(ref_model(in_a, in_b, in_op));
        hold = out_valid && !out_ready;
        p_res = out_result;
        p_err = out_error;
      end
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
  endtask
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    in_valid = 1'b0;
    clr_cnt = 1'b0;
    repeat (n) step;
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vec_t vt[12];
    exp_t e3[3];
    logic acc;
    int idx, d, seen;
    vt[0]  = '{4'h1, 4'h8, 2'd1, 4'h9, 1'b1, 3'b011, 1};
    vt[1]  = '{4'h7, 4'h1, 2'd0, 4'h8, 1'b1, 3'b011, 2};
    vt[2]  = '{4'hF, 4'hF, 2'd2, 4'h0, 1'b0, 3'b110, 2};
    vt[3]  = '{4'h5, 4'h5, 2'd3, 4'h0, 1'b0, 3'b110, 2};
    vt[4]  = '{4'h3, 4'h4, 2'd0, 4'h7, 1'b0, 3'b000, 2};
    vt[5]  = '{4'hA, 4'h5, 2'd3, 4'hF, 1'b0, 3'b001, 2};
    vt[6]  = '{4'h8, 4'h1, 2'd1, 4'h7, 1'b1, 3'b010, 3};
    vt[7]  = '{4'h8, 4'h8, 2'd0, 4'h0, 1'b1, 3'b110, 4};
    vt[8]  = '{4'h0, 4'h0, 2'd2, 4'hF, 1'b0, 3'b011, 4};
    vt[9]  = '{4'h0, 4'h8, 2'd1, 4'h8, 1'b1, 3'b011, 5};
    vt[10] = '{4'hF, 4'h1, 2'd0, 4'h0, 1'b0, 3'b100, 5};
    vt[11] = '{4'h5, 4'h5, 2'd1, 4'h0, 1'b0, 3'b100, 5};
    in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    do_reset(2);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_in_ready_low", in_ready, 0);
    rst_n = 1'b1;
    mon_on = 1'b1;
    step;
    chk("rst_in_ready_after", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      send(vt[i].a, vt[i].b, vt[i].op);
      out_ready = 1'b1;
      #1;
      chk("vec_in_ready", in_ready, 1);
      step;
      in_valid = 1'b0;
      chk("vec_lat_no_valid", out_valid, 0);
      step;
      chk("vec_valid", out_valid, 1);
      chk("vec_result", out_result, vt[i].res);
      chk("vec_error", out_error, vt[i].err);
      step;
      chk("vec_flags", flags, vt[i].fl);
      chk("vec_err_count", err_count, vt[i].cnt);
      chk("vec_drained", out_valid, 0);
    end
    e3[0] = ref_model(4'h1, 4'h2, 2'd0);
    e3[1] = ref_model(4'h6, 4'h2, 2'd1);
    e3[2] = ref_model(4'h9, 4'h6, 2'd3);
    chk("stall_model_sanity", e3[2].res, 4'hF);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx == 0) send(4'h1, 4'h2, 2'd0);
      if (idx == 1) send(4'h6, 4'h2, 2'd1);
      if (idx == 2) send(4'h9, 4'h6, 2'd3);
      #1;
      acc = in_valid & in_ready;
      step;
      if (acc) idx++;
    end
    #1;
    chk("stall_accepted", idx, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_result", out_result, e3[0].res);
    out_ready = 1'b1;
    d = 0;
    for (int c = 0; c < 12 && d < 3; c++) begin
      if (idx == 2) send(4'h9, 4'h6, 2'd3);
      else in_valid = 1'b0;
      #1;
      acc = in_valid & in_ready;
      if (out_valid && out_ready) begin
        chk("stall_order", out_result, e3[d].res);
        d++;
      end
      step;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("stall_delivered", d, 3);
    do_reset(1);
    step;
    out_ready = 1'b1;
    send(4'h7, 4'h1, 2'd0);
    repeat (4) step;
    in_valid = 1'b0;
    repeat (3) step;
    chk("sat_cnt2", err_count2, 3);
    chk("sat_cnt8", err_count, 4);
    send(4'h7, 4'h1, 2'd0);
    step;
    in_valid = 1'b0;
    step;
    chk("clr_pre_valid", out_valid, 1);
    clr_cnt = 1'b1;
    step;
    clr_cnt = 1'b0;
    chk("clr_cnt2", err_count2, 0);
    chk("clr_cnt8", err_count, 0);
    chk("clr_flags_v", flags[1], 1);
    out_ready = 1'b0;
    send(4'h2, 4'h3, 2'd0);
    step;
    send(4'h4, 4'h4, 2'd3);
    step;
    in_valid = 1'b0;
    #1;
    chk("flush_s1_full", in_ready, 0);
    chk("flush_s2_full", out_valid, 1);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      step;
      if (out_valid) seen++;
    end
    chk("flush_never_delivered", seen, 0);
    for (int c = 0; c < 500; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_a = 4'($urandom);
      in_b = 4'($urandom);
      in_op = 2'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      clr_cnt = $urandom_range(0, 15) == 0;
      step;
    end
    in_valid = 1'b0;
    clr_cnt = 1'b0;
    out_ready = 1'b1;
    repeat (4) step;
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits.
REQ-002 Parameter CNT_W, default 8, width of the error counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  request present on in_a/in_b/in_op.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 in_a  input  WIDTH  operand 1, two's complement.
REQ-008 in_b  input  WIDTH  operand 2, two's complement.
REQ-009 in_op  input  2  opcode: 0 ADD, 1 SUB, 2 NAND, 3 XOR.
REQ-010 out_valid  output  1  result present on out_result/out_error.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_result  output  WIDTH  registered result.
REQ-013 out_error  output  1  registered signed-overflow flag.
REQ-014 flags  output  3  {Z,V,N} condition flags.
REQ-015 clr_cnt  input  1  synchronous clear of err_count.
REQ-016 err_count  output  CNT_W  count of delivered results with out_error=1.

Function
REQ-017 Transfer in: in_valid & in_ready at a rising edge; transfer out: out_valid & out_ready at a rising edge.
REQ-018 Two stages: S1 holds the accepted operands/opcode; S2 holds the computed result/error; each has a valid bit.
REQ-019 S1 advances to S2 when S2 is empty or S2 transfers out in the same edge; S2 captures the result computed from S1.
REQ-020 in_ready = !S1.valid | S1 advances this cycle (combinational from out_ready permitted).
REQ-021 Latency: request accepted at edge k with S2 draining -> out_valid high after edge k+1; throughput 1 per cycle with out_ready held high.
REQ-022 While out_valid=1 and out_ready=0, out_result and out_error are held stable; results are delivered in accept order, none dropped or duplicated.
REQ-023 ADD/SUB results wrap modulo 2^WIDTH; no saturation.
REQ-024 ADD error = a,b same sign and result sign differs; SUB error = a,b signs differ and result sign differs from a.
REQ-025 NAND = ~(a&b), XOR = a^b, both bitwise; error = 0.
REQ-026 Flags update only on transfer out: Z = (result==0); N = result MSB; V = error for ADD/SUB, unchanged for NAND/XOR.
REQ-027 err_count increments by 1 on each transfer out with out_error=1, saturating at 2^CNT_W-1.
REQ-028 clr_cnt=1 sets err_count to 0 and takes priority over a simultaneous increment (that increment is lost).

Reset
REQ-029 rst_n=0 at an edge: S1.valid=0, S2.valid=0, out_valid=0, out_result=0, out_error=0, flags=000, err_count=0; in-flight requests discarded.
REQ-030 in_ready=1 from the first cycle after rst_n returns high; in_ready=0 while rst_n=0.

Structure
REQ-031 Package alu_pkg holds the opcode enum (ADD, SUB, NAND, XOR) and flag bit-index constants (FLAG_Z=2, FLAG_V=1, FLAG_N=0).
REQ-032 Combinational sub-module alu_core (WIDTH param) computes result and error from a, b, op; alu_pipe instantiates it between S1 and S2.

Verification
REQ-033 rst_n low 2 cycles -> out_valid=0, flags=000, err_count=0; in_ready=1 the cycle after release.
REQ-034 SUB a=4'h1, b=4'h8, out_ready=1 -> out_valid after 2 edges, out_result=4'h9, out_error=1, flags=3'b011, err_count=1.
REQ-035 ADD 4'h7+4'h1 -> 4'h8, error=1; then NAND 4'hF,4'hF -> 4'h0, error=0, flags=3'b110 (V retained).
REQ-036 out_ready=0 for 6 cycles while 3 requests offered -> 2 accepted then in_ready=0, output held stable; release -> all 3 delivered in order.
REQ-037 CNT_W=2, 4 overflowing ADDs -> err_count=3; clr_cnt asserted on an overflowing transfer -> err_count=0.
REQ-038 rst_n low one cycle with S1 and S2 full -> out_valid=0 next cycle, neither result ever delivered.
